// File: rtl/word_holder_pkg.sv
// Shared constants and helpers for the word_holder serial indicator.
// The frame is eight slots long: a start marker, the four data bits MSB
// first, then three idle slots.
package word_holder_pkg;

  localparam int FRAME_SLOTS = 8;
  localparam int SLOT_W      = 3;
  localparam int WORD_W      = 4;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam logic START_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b0;

  localparam slot_t SLOT_START = slot_t'(0);
  localparam slot_t SLOT_D3    = slot_t'(1);
  localparam slot_t SLOT_D2    = slot_t'(2);
  localparam slot_t SLOT_D1    = slot_t'(3);
  localparam slot_t SLOT_D0    = slot_t'(4);
  localparam slot_t SLOT_LAST  = slot_t'(FRAME_SLOTS - 1);

  // Line level for a given slot of a frame carrying 'word'.
  function automatic logic slot_level(input slot_t slot, input word_t word);
    logic level;
    level = IDLE_LEVEL;
    case (slot)
      SLOT_START: level = START_LEVEL;
      SLOT_D3:    level = word[3];
      SLOT_D2:    level = word[2];
      SLOT_D1:    level = word[1];
      SLOT_D0:    level = word[0];
      default:    level = IDLE_LEVEL;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/word_holder_sync_edge.sv
// Multi-flop synchroniser for asynchronous inputs, with a registered
// rising-edge pulse that is high on the same cycle the synced output first
// reads 1. Callers that only need the synced level leave the pulse unused.
module word_holder_sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the raw input through the chain; the pulse looks one stage ahead so
  // it lines up with the chain output rather than trailing it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      rise <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      rise <= chain[STAGES-2] & ~chain[STAGES-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/word_holder.sv
// word_holder: captures a 4-bit switch word on a write-button rising edge and
// streams it forever as an 8-slot serial frame on 'out'. A new word is only
// adopted at the start of a frame, so a frame is never torn.
module word_holder
  import word_holder_pkg::*;
#(
  parameter int BIT_CYCLES  = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic sw1,
  input  logic sw2,
  input  logic sw3,
  input  logic sw4,
  input  logic write,
  output logic out
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

  word_t            word_s;
  word_t            unused_sw_rise;
  logic             unused_write_s;
  logic             write_rise;
  word_t            pending;
  word_t            frame;
  slot_t            slot_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_start;

  word_holder_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(WORD_W)) u_sync_sw (
    .clk   (sysclk),
    .rst_n (rst_n),
    .d     ({sw4, sw3, sw2, sw1}),
    .q     (word_s),
    .rise  (unused_sw_rise)
  );

  word_holder_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_write (
    .clk   (sysclk),
    .rst_n (rst_n),
    .d     (write),
    .q     (unused_write_s),
    .rise  (write_rise)
  );

  assign frame_start = (slot_cnt == SLOT_START) && (bit_cnt == '0);

  // Latch the synced switch word on each write rising edge.
  always_ff @(posedge sysclk) begin
    if (!rst_n) pending <= '0;
    else if (write_rise) pending <= word_s;
  end

  // Adopt the pending word on the first cycle of slot 0; a same-cycle capture
  // is therefore seen one frame later.
  always_ff @(posedge sysclk) begin
    if (!rst_n) frame <= '0;
    else if (frame_start) frame <= pending;
  end

  // Bit-time counter inside a slot, and slot counter wrapping after the last slot.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      slot_cnt <= SLOT_START;
    end else if (bit_cnt == BIT_LAST) begin
      bit_cnt  <= '0;
      slot_cnt <= (slot_cnt == SLOT_LAST) ? SLOT_START : slot_cnt + slot_t'(1);
    end else begin
      bit_cnt  <= bit_cnt + CNT_W'(1);
    end
  end

  // Registered line level, one cycle behind the counters.
  always_ff @(posedge sysclk) begin
    if (!rst_n) out <= IDLE_LEVEL;
    else out <= slot_level(slot_cnt, frame);
  end

endmodule

// File: tb/tb_word_holder.sv
// Bench for word_holder with short bit slots. A behavioural model predicts
// the line level from the frame rules: a capture lands SYNC_STAGES+1 edges
// after the raw write edge, frames are 8*BIT_CYCLES long from reset release,
// and a frame is the 8-bit pattern {1, word, 000} sent MSB first.
module tb_word_holder;

  localparam int BC = 4;
  localparam int SS = 2;
  localparam int FP = 8 * BC;

  logic clk;
  logic rst_n;
  logic sw1, sw2, sw3, sw4;
  logic write;
  logic out;

  int tests_run = 0;
  int fails     = 0;

  // Model state.
  int         c;
  logic [3:0] m_pending;
  logic [3:0] m_frame;
  logic [3:0] h_sw [1:3];
  logic       h_w  [1:3];
  logic       exp_out;

  word_holder #(.BIT_CYCLES(BC), .SYNC_STAGES(SS)) dut (
    .sysclk (clk),
    .rst_n  (rst_n),
    .sw1    (sw1),
    .sw2    (sw2),
    .sw3    (sw3),
    .sw4    (sw4),
    .write  (write),
    .out    (out)
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Level at position p (0..FP-1) of a frame carrying word w.
  function automatic logic frame_level(input int p, input logic [3:0] w);
    logic [7:0] pattern;
    pattern = {1'b1, w, 3'b000};
    return pattern[7 - (p / BC)];
  endfunction

  // Spec-level start-of-frame shape right after reset with pending = 0.
  function automatic logic empty_frame_level(input int i);
    return ((i % FP) < BC) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      c = 0;
      m_pending = 4'd0;
      m_frame = 4'd0;
      exp_out = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        h_sw[k] = 4'd0;
        h_w[k]  = 1'b0;
      end
    end else begin
      if ((c % FP) == 0) m_frame = m_pending;
      if (h_w[2] && !h_w[3]) m_pending = h_sw[2];
      exp_out = frame_level(c % FP, m_frame);
      c++;
      h_w[3] = h_w[2]; h_w[2] = h_w[1]; h_w[1] = write;
      h_sw[3] = h_sw[2]; h_sw[2] = h_sw[1]; h_sw[1] = {sw4, sw3, sw2, sw1};
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_word(input logic [3:0] w);
    {sw4, sw3, sw2, sw1} = w;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    write = 1'b0;
    set_word(4'd0);
    repeat (5) begin
      step();
      tests_run++;
      if (out !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: out=%b expected 0", out);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FP; i++) begin
      step();
      tests_run++;
      if (out !== exp_out || out !== empty_frame_level(i)) begin
        fails++;
        $display("FAIL reset_first_frames: out=%b expected %b at cycle %0d", out, empty_frame_level(i), i);
      end
    end
  endtask

  task automatic test_capture();
    set_word(4'b0001);
    write = 1'b1;
    for (int i = 0; i < 10 + 3 * FP; i++) begin
      if (i == 10) write = 1'b0;
      step();
      tests_run++;
      if (out !== exp_out) begin
        fails++;
        $display("FAIL capture: out=%b expected %b at frame pos %0d", out, exp_out, (c - 1) % FP);
      end
    end
  endtask

  task automatic test_no_edge();
    set_word(4'b0111);
    write = 1'b0;
    for (int i = 0; i < 40 + 3 + 3 * FP; i++) begin
      if (i == 40) write = 1'b1;
      if (i == 43) write = 1'b0;
      step();
      tests_run++;
      if (out !== exp_out) begin
        fails++;
        $display("FAIL no_edge: out=%b expected %b at frame pos %0d", out, exp_out, (c - 1) % FP);
      end
    end
  endtask

  task automatic test_held_write();
    write = 1'b1;
    for (int i = 0; i < 60 + 5 + 3 + 3 * FP; i++) begin
      if (i == 10) set_word(4'b1111);
      if (i == 60) write = 1'b0;
      if (i == 65) write = 1'b1;
      if (i == 68) write = 1'b0;
      step();
      tests_run++;
      if (out !== exp_out) begin
        fails++;
        $display("FAIL held_write: out=%b expected %b at frame pos %0d", out, exp_out, (c - 1) % FP);
      end
    end
  endtask

  task automatic test_collision();
    int budget;
    write = 1'b0;
    budget = 0;
    // The raw edge is placed two edges before a frame load so that the capture
    // lands on the load cycle.
    while ((c % FP) != FP - SS && budget < 2 * FP) begin
      step();
      budget++;
      tests_run++;
      if (out !== exp_out) begin
        fails++;
        $display("FAIL collision_wait: out=%b expected %b", out, exp_out);
      end
    end
    tests_run++;
    if ((c % FP) != FP - SS) begin
      fails++;
      $display("FAIL collision_align: pos=%0d expected %0d", c % FP, FP - SS);
    end
    set_word(4'b0101);
    write = 1'b1;
    for (int i = 0; i < 3 * FP; i++) begin
      if (i == 4) write = 1'b0;
      step();
      tests_run++;
      if (out !== exp_out) begin
        fails++;
        $display("FAIL collision: out=%b expected %b at frame pos %0d", out, exp_out, (c - 1) % FP);
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    set_word(4'b1111);
    write = 1'b1;
    for (int i = 0; i < 3 + 3 * FP; i++) begin
      if (i == 3) write = 1'b0;
      step();
      tests_run++;
      if (out !== exp_out) begin
        fails++;
        $display("FAIL reset_mid_load: out=%b expected %b", out, exp_out);
      end
    end
    budget = 0;
    while ((c % FP) != 3 * BC + BC / 2 && budget < 2 * FP) begin
      step();
      budget++;
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (out !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_abort: out=%b expected 0", out);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FP; i++) begin
      step();
      tests_run++;
      if (out !== exp_out || out !== empty_frame_level(i)) begin
        fails++;
        $display("FAIL reset_mid_after: out=%b expected %b at cycle %0d", out, empty_frame_level(i), i);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 1;
    write = 1'b0;
    for (int i = 0; i < 500; i++) begin
      hold--;
      if (hold == 0) begin
        write = ~write;
        hold = $urandom_range(1, 40);
      end
      if ($urandom_range(0, 7) == 0) set_word(4'($urandom_range(0, 15)));
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      step();
      tests_run++;
      if (out !== exp_out) begin
        fails++;
        $display("FAIL random: out=%b expected %b at step %0d", out, exp_out, i);
      end
    end
    rst_n = 1'b1;
  endtask

  // Sequence and final report
  initial begin
    c = 0;
    m_pending = 4'd0;
    m_frame = 4'd0;
    exp_out = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      h_sw[k] = 4'd0;
      h_w[k]  = 1'b0;
    end
    rst_n = 1'b0;
    write = 1'b0;
    set_word(4'd0);
    @(negedge clk);
    test_reset();
    test_capture();
    test_no_edge();
    test_held_write();
    test_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
